// File: rtl/au_serial.sv
// Serial add/sub/compare/accumulate unit: CHUNK bits per cycle LSB first, done pulse N cycles after start.
// Optional AU_SAT_EN: ADD/SUB/ACC results saturate on signed overflow instead of wrapping.
module au_serial #(
  parameter int WIDTH = 6,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] resultado,
  output logic             carryOut,
  output logic             overflow,
  output logic             igual,
  output logic             diferente,
  output logic             menor
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = $clog2(N + 1);
  localparam logic [1:0] OP_ADD = 2'b00, OP_SUB = 2'b01, OP_CMP = 2'b10, OP_ACC = 2'b11;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                 state;
  logic [CW-1:0]          cnt_q;
  logic [1:0]             op_q;
  logic [WIDTH-1:0]       x_q, y_q, acc_q;
  logic [WIDTH-CHUNK-1:0] sum_q;
  logic                   carry_q, eq_q;

  logic [CHUNK:0]   csum;
  logic             cin_msb, ovf, sub_q;
  logic [WIDTH-1:0] full, res_v;

  // SUB and CMP are the two encodings with differing bits.
  assign sub_q = op_q[1] ^ op_q[0];

  always_comb begin
    csum    = {1'b0, x_q[CHUNK-1:0]} + {1'b0, y_q[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry_q};
    // carry into the chunk MSB recovered from its sum bit
    cin_msb = csum[CHUNK-1] ^ x_q[CHUNK-1] ^ y_q[CHUNK-1];
    ovf     = cin_msb ^ csum[CHUNK];
    full    = {csum[CHUNK-1:0], sum_q};
    res_v   = full;
    if (op_q == OP_CMP)
      res_v = eq_q ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
`ifdef AU_SAT_EN
    else if (ovf)
      res_v = x_q[CHUNK-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt_q     <= '0;
      op_q      <= OP_ADD;
      x_q       <= '0;
      y_q       <= '0;
      acc_q     <= '0;
      sum_q     <= '0;
      carry_q   <= 1'b0;
      eq_q      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      resultado <= '0;
      carryOut  <= 1'b0;
      overflow  <= 1'b0;
      igual     <= 1'b0;
      diferente <= 1'b0;
      menor     <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            state <= RUN;
            busy  <= 1'b1;
            cnt_q <= '0;
            op_q  <= op;
            if (op == OP_ACC) begin
              x_q     <= acc_q;
              y_q     <= A;
              eq_q    <= (acc_q == A);
              carry_q <= 1'b0;
            end else begin
              x_q     <= A;
              y_q     <= (op == OP_SUB || op == OP_CMP) ? ~B : B;
              eq_q    <= (A == B);
              carry_q <= (op == OP_SUB || op == OP_CMP);
            end
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          x_q     <= x_q >> CHUNK;
          y_q     <= y_q >> CHUNK;
          carry_q <= csum[CHUNK];
          sum_q   <= full[WIDTH-1:CHUNK];
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == CW'(N - 1)) begin
            state     <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            resultado <= res_v;
            carryOut  <= csum[CHUNK];
            overflow  <= ovf;
            igual     <= eq_q;
            diferente <= ~eq_q;
            menor     <= sub_q & ~csum[CHUNK];
            if (op_q == OP_ACC)
              acc_q <= res_v;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
